// File: rtl/pattern_tx_if.sv
// Handshake and serial-stream bundle for pattern_tx.
// The slave modport is the transmitter side and the master modport is the word source/monitor.
interface pattern_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             count_clr;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             expect_out;
  logic [15:0]      match_count;

  modport slave (
    input  data_in,
    input  data_valid,
    input  count_clr,
    output data_ready,
    output bit_out,
    output bit_valid,
    output busy,
    output expect_out,
    output match_count
  );

  modport master (
    output data_in,
    output data_valid,
    output count_clr,
    input  data_ready,
    input  bit_out,
    input  bit_valid,
    input  busy,
    input  expect_out,
    input  match_count
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts accepted words out MSB-first with no gaps between words,
// and runs a shadow "101" Moore detector on the sent bits to give expected output and match count.
module pattern_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input logic         clk,
  input logic         areset_n,
  pattern_tx_if.slave tx_if
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  typedef enum logic [1:0] {
    ShA = 2'd0,
    ShB = 2'd1,
    ShC = 2'd2,
    ShD = 2'd3
  } shadow_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bcnt_q, bcnt_d;
  shadow_e          shadow_q, shadow_d;
  logic [15:0]      count_q, count_d;

  logic shifting;
  logic last_bit;
  logic ready;
  logic accept;
  logic tx_bit;
  logic enter_d;

  assign shifting = (state_q == StShift);
  assign last_bit = shifting && (bcnt_q == LastCnt);
  // Ready is a pure register decode so the source may wait on it before raising valid.
  assign ready    = !shifting || last_bit;
  assign accept   = tx_if.data_valid && ready;
  assign tx_bit   = shifting ? shreg_q[WIDTH-1] : IDLE_BIT;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = tx_if.data_in;
          bcnt_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = shreg_q << 1;
        bcnt_d  = bcnt_q + CntW'(1);
        if (last_bit) begin
          // A reload on the last bit keeps the stream gapless.
          if (accept) begin
            shreg_d = tx_if.data_in;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Shadow detector only advances on payload bits; idle cycles leave it untouched.
  always_comb begin
    shadow_d = shadow_q;
    if (shifting) begin
      case (shadow_q)
        ShA:     shadow_d = tx_bit ? ShB : ShA;
        ShB:     shadow_d = tx_bit ? ShB : ShC;
        ShC:     shadow_d = tx_bit ? ShD : ShA;
        ShD:     shadow_d = tx_bit ? ShB : ShC;
        default: shadow_d = ShA;
      endcase
    end
  end

  // D has no self-loop, so a payload edge landing in D is always a fresh entry.
  assign enter_d = shifting && (shadow_d == ShD);

  always_comb begin
    count_d = count_q;
    if (tx_if.count_clr) begin
      count_d = '0;
    end else if (enter_d && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      shadow_q <= ShA;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign tx_if.data_ready  = ready;
  assign tx_if.bit_out     = tx_bit;
  assign tx_if.bit_valid   = shifting;
  assign tx_if.busy        = shifting;
  assign tx_if.expect_out  = (shadow_q == ShD);
  assign tx_if.match_count = count_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: directed test-plan scenarios plus random traffic, checked every cycle
// against a queue-of-bits transmitter model and a last-three-bits "101" match model.
module tb_pattern_tx;

  localparam int unsigned W        = 8;
  localparam logic        IdleBit  = 1'b1;

  logic clk;
  logic areset_n;

  pattern_tx_if #(.WIDTH(W)) tx_if ();

  pattern_tx #(
    .WIDTH    (W),
    .IDLE_BIT (IdleBit)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .tx_if    (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int bv_cnt;

  // Reference model: bits still to appear on the wire, plus the sent-bit history.
  bit          bitq[$];
  logic [2:0]  hist;
  int          nbits;
  logic [15:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_expect();
    return (nbits >= 3) && (hist == 3'b101);
  endfunction

  // True when the coming edge consumes a bit that completes "101".
  function automatic logic m_match_next();
    logic [2:0] h;
    if (bitq.size() == 0) return 1'b0;
    h = {hist[1:0], bitq[0]};
    return (nbits >= 2) && (h == 3'b101);
  endfunction

  task automatic model_reset();
    bitq.delete();
    hist  = 3'b000;
    nbits = 0;
    m_cnt = 16'd0;
  endtask

  task automatic compare_all();
    logic e_valid;
    e_valid = (bitq.size() > 0);
    check_eq("bit_valid", 32'(tx_if.bit_valid), 32'(e_valid));
    check_eq("busy", 32'(tx_if.busy), 32'(e_valid));
    check_eq("bit_out", 32'(tx_if.bit_out), 32'(e_valid ? bitq[0] : IdleBit));
    check_eq("data_ready", 32'(tx_if.data_ready), 32'(bitq.size() <= 1));
    check_eq("expect_out", 32'(tx_if.expect_out), 32'(m_expect()));
    check_eq("match_count", 32'(tx_if.match_count), 32'(m_cnt));
    if (tx_if.bit_valid === 1'b1) bv_cnt++;
  endtask

  // One clock: inputs are already driven; update the model on the edge and compare at +1.
  task automatic step();
    logic       acc;
    logic       hit;
    logic [W-1:0] w;
    acc = tx_if.data_valid && (bitq.size() <= 1);
    w   = tx_if.data_in;
    hit = m_match_next();
    @(posedge clk);
    if (bitq.size() > 0) begin
      hist = {hist[1:0], bitq.pop_front()};
      nbits++;
    end
    if (tx_if.count_clr) m_cnt = 16'd0;
    else if (hit && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (acc) for (int i = W - 1; i >= 0; i--) bitq.push_back(w[i]);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit keep);
    logic acc;
    int   n;
    tx_if.data_in    = w;
    tx_if.data_valid = 1'b1;
    n = 0;
    do begin
      acc = (bitq.size() <= 1);
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    if (!keep) tx_if.data_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bitq.size() > 0 && n < 100) begin
      step();
      n++;
    end
    if (bitq.size() > 0) check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    tx_if.data_valid = 1'b0;
    tx_if.count_clr  = 1'b0;
    tx_if.data_in    = '0;
    areset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    areset_n = 1'b1;
    step();
    bv_cnt = 0;
  endtask

  initial begin
    bit done;
    n_vec = 0;
    n_err = 0;
    bv_cnt = 0;
    areset_n = 1'b1;
    tx_if.data_in = '0;
    tx_if.data_valid = 1'b0;
    tx_if.count_clr = 1'b0;
    model_reset();
    #2;

    // Reset state.
    do_reset();
    check_eq("rst_ready", 32'(tx_if.data_ready), 32'd1);

    // Single word A5.
    send_word(8'hA5, 1'b0);
    drain();
    check_eq("a5_bits", 32'(bv_cnt), 32'd8);
    check_eq("a5_count", 32'(tx_if.match_count), 32'd2);
    step();

    // Overlap AA then 80 (C -> D across the word boundary).
    do_reset();
    send_word(8'hAA, 1'b0);
    drain();
    check_eq("aa_count", 32'(tx_if.match_count), 32'd3);
    send_word(8'h80, 1'b0);
    drain();
    check_eq("aa80_count", 32'(tx_if.match_count), 32'd4);

    // Back-to-back FF, 00.
    do_reset();
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b0);
    drain();
    check_eq("b2b_bits", 32'(bv_cnt), 32'd16);
    check_eq("b2b_busy", 32'(tx_if.busy), 32'd0);
    check_eq("b2b_count", 32'(tx_if.match_count), 32'd0);

    // Idle gap across a word boundary.
    do_reset();
    send_word(8'h01, 1'b0);
    drain();
    for (int i = 0; i < 5; i++) step();
    send_word(8'h40, 1'b0);
    drain();
    check_eq("gap_count", 32'(tx_if.match_count), 32'd1);

    // Clear on the edge that enters D.
    do_reset();
    done = 1'b0;
    send_word(8'hA5, 1'b0);
    for (int i = 0; i < 20 && bitq.size() > 0; i++) begin
      if (!done && m_match_next()) begin
        tx_if.count_clr = 1'b1;
        step();
        tx_if.count_clr = 1'b0;
        check_eq("clr_collide", 32'(tx_if.match_count), 32'd0);
        done = 1'b1;
      end else begin
        step();
      end
    end
    check_eq("clr_after", 32'(tx_if.match_count), 32'd1);

    // Reset mid-word.
    do_reset();
    send_word(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) step();
    #2;
    areset_n = 1'b0;
    #1;
    check_eq("mid_valid", 32'(tx_if.bit_valid), 32'd0);
    check_eq("mid_busy", 32'(tx_if.busy), 32'd0);
    check_eq("mid_bit", 32'(tx_if.bit_out), 32'(IdleBit));
    check_eq("mid_ready", 32'(tx_if.data_ready), 32'd1);
    check_eq("mid_expect", 32'(tx_if.expect_out), 32'd0);
    check_eq("mid_count", 32'(tx_if.match_count), 32'd0);
    model_reset();
    #3;
    areset_n = 1'b1;
    step();
    check_eq("mid_rel_ready", 32'(tx_if.data_ready), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tx_if.data_valid = ($urandom_range(0, 3) != 0);
      tx_if.data_in    = W'($urandom);
      tx_if.count_clr  = ($urandom_range(0, 63) == 0);
      step();
    end
    tx_if.data_valid = 1'b0;
    tx_if.count_clr  = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter: the driving end of the single-bit `in` stream consumed by the team's 4-state Moore "101" sequence detector. Parallel words are accepted over a valid/ready handshake and shifted out MSB-first, one bit per clock, with gapless back-to-back streaming. An internal shadow copy of the detector FSM runs on the transmitted bits and provides the expected detector output and a running match count, so benches check the detector against it cycle for cycle.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal values are 2 to 32.
- `IDLE_BIT`, 1'b0: value driven on `bit_out` when no word is being shifted.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `areset_n`, input, 1: asynchronous, active-low reset.
- `data_in`, input, WIDTH: word to transmit. Sampled on handshake.
- `data_valid`, input, 1: `data_in` is valid.
- `data_ready`, output, 1: the block can accept a word this cycle.
- `count_clr`, input, 1: synchronous clear of `match_count`.
- `bit_out`, output, 1: serial bit. This is the detector's `in`.
- `bit_valid`, output, 1: `bit_out` carries a payload bit.
- `busy`, output, 1: a word is being shifted.
- `expect_out`, output, 1: expected detector `out`. High when the shadow FSM is in D.
- `match_count`, output, 16: number of entries into D. Saturates at 16'hFFFF.

## Operation
- Main FSM has two states, IDLE and SHIFT. It holds a WIDTH-bit shift register and a bit counter `bcnt` of width $clog2(WIDTH).
- `data_ready` = (IDLE) | (SHIFT & `bcnt`==WIDTH-1). It is decoded from registers only and never depends on `data_valid`.
- Accept happens when `data_valid & data_ready` at a clock edge. On accept:
  - the shift register loads `data_in`;
  - `bcnt` is set to 0;
  - the state goes to SHIFT.
- In SHIFT:
  - `bit_out` = shift register MSB, and `bit_valid` = `busy` = 1.
  - Each edge shifts left by 1 and increments `bcnt`.
  - At `bcnt`==WIDTH-1 the state returns to IDLE, unless an accept occurs on the same edge, in which case it reloads and stays in SHIFT.
- In IDLE: `bit_out` = IDLE_BIT, and `bit_valid` = `busy` = 0. `data_in` is ignored when `data_valid` is 0.
- Shadow FSM has states A=2'd0, B=1, C=2, D=3. It advances only on edges where `bit_valid`=1, using `bit_out` as input:
  - A: 0→A, 1→B
  - B: 0→C, 1→B
  - C: 0→A, 1→D
  - D: 0→C, 1→B
- The shadow FSM holds its state on idle cycles. The detector under test must therefore be gated by `bit_valid`.
- `match_count` increments on each edge where the shadow's next state is D.
  - It stops incrementing at 16'hFFFF.
  - When `count_clr`=1, the count becomes 0 on that edge. Clear wins over a simultaneous increment.
- Overlapping patterns count individually: "10101" yields 2.

## Timing
- Reset, asynchronous on `areset_n`=0:
  - state = IDLE, shift register = 0, `bcnt` = 0, shadow = A, `match_count` = 0;
  - outputs: `data_ready`=1, `bit_valid`=0, `busy`=0, `bit_out`=IDLE_BIT, `expect_out`=0.
- Reset mid-word discards the remaining bits. The first edge after release behaves as from IDLE.
- Latency: accept at edge k puts the MSB on `bit_out` during cycle k→k+1. The LSB appears in cycle k+WIDTH-1→k+WIDTH.
- Throughput: one word per WIDTH cycles when `data_valid` is held high. `bit_valid` has no gaps between words.
- `expect_out` is a registered-state decode. It is high in the cycle after the edge that consumed the third bit of "101". This matches the Moore detector fed the same stream.
- `data_valid` deasserted at the last bit means IDLE follows on the next edge. Shadow state is retained across words and idle gaps, so patterns spanning word boundaries count.

## Test plan
- **Single word.** Reset, then send WIDTH=8 word 8'hA5 (bits 1,0,1,0,0,1,0,1).
  - `bit_valid` is high for exactly 8 cycles with the bits in that order.
  - `expect_out` pulses after the 3rd and 8th bits.
  - `match_count`=2, and `data_ready` returns high with the last bit.
- **Overlap.** Send 8'hAA. `match_count`=3 and shadow ends in C. Follow with 8'h80: the leading 1 makes C→D, so count=4.
- **Back-to-back.** Hold `data_valid`=1 with 8'hFF then 8'h00. `bit_valid` stays high for 16 consecutive cycles with no gap; `match_count`=0; `busy` drops on the 17th cycle.
- **Idle gap across boundary.** Send 8'h01, wait 5 idle cycles, then send 8'h40. The pattern 1|01 spans the gap, so count=1. `bit_out`=IDLE_BIT during the gap and the shadow does not advance.
- **Clear collision.** Assert `count_clr` on the same edge that enters D. `match_count`=0 after that edge, and the next match gives 1.
- **Reset mid-word.** Pull `areset_n` low after 3 bits of 8'hA5. All outputs go to reset values immediately, without waiting for a clock. After release, `data_ready`=1 and `match_count`=0.
